// File: rtl/display_pkg.sv
`default_nettype none
// display_pkg: shared types and constants for the boot display path.
package display_pkg;

  localparam int LCD_WIDTH  = 480;
  localparam int LCD_HEIGHT = 272;
  localparam int PIX_ADDR_W = 17;

  typedef logic [23:0]           rgb888_t;
  typedef logic [PIX_ADDR_W-1:0] pix_addr_t;

  typedef enum logic [2:0] {
    ST_BOOT        = 3'd0,
    ST_LS_IDLE     = 3'd1,
    ST_LS_RENDER   = 3'd2,
    ST_MAIN_IDLE   = 3'd3,
    ST_MAIN_RENDER = 3'd4
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_source_sequencer_if.sv
`default_nettype none
// frame_source_sequencer_if: frame tick, pixel sources and framebuffer write port.
interface frame_source_sequencer_if;
  import display_pkg::*;

  logic      vsync_tick;
  logic      app_ready;
  logic      ls_bsy;
  logic      ls_valid;
  rgb888_t   ls_color;
  logic      main_valid;
  rgb888_t   main_color;
  logic      ls_new_frame;
  logic      main_new_frame;
  logic      fb_we;
  pix_addr_t fb_addr;
  rgb888_t   fb_data;
  logic      loading_active;
  logic      overrun;
  logic [7:0] skipped_frames;

  // master: the sequencer itself
  modport master (
    input  vsync_tick, app_ready, ls_bsy, ls_valid, ls_color, main_valid, main_color,
    output ls_new_frame, main_new_frame, fb_we, fb_addr, fb_data,
           loading_active, overrun, skipped_frames
  );

  // slave: the surrounding timing block, pixel sources and framebuffer
  modport slave (
    output vsync_tick, app_ready, ls_bsy, ls_valid, ls_color, main_valid, main_color,
    input  ls_new_frame, main_new_frame, fb_we, fb_addr, fb_data,
           loading_active, overrun, skipped_frames
  );

endinterface
`default_nettype wire

// File: rtl/frame_source_sequencer_fb_write_mux.sv
`default_nettype none
// fb_write_mux: selects the active pixel source, counts pixels into the
// framebuffer and flags pixels that arrive once the frame is already full.
module fb_write_mux
  import display_pkg::*;
#(
  parameter int NPIX = LCD_WIDTH * LCD_HEIGHT
) (
  input  logic      clk_12,
  input  logic      rst,
  input  logic      write_en,
  input  logic      sel_main,
  input  logic      frame_start,
  input  logic      ls_valid,
  input  rgb888_t   ls_color,
  input  logic      main_valid,
  input  rgb888_t   main_color,
  output logic      fb_we,
  output pix_addr_t fb_addr,
  output rgb888_t   fb_data,
  output logic      overrun,
  output logic      frame_done
);

  localparam pix_addr_t FULL = pix_addr_t'(NPIX);
  localparam pix_addr_t LAST = pix_addr_t'(NPIX - 1);

  pix_addr_t pix_cnt;
  logic      src_valid;
  rgb888_t   src_color;
  logic      full;
  logic      accept;

  always_comb begin
    src_valid  = sel_main ? main_valid : ls_valid;
    src_color  = sel_main ? main_color : ls_color;
    full       = (pix_cnt == FULL);
    accept     = write_en && src_valid && !full;
    frame_done = accept && (pix_cnt == LAST);
  end

  // pix_cnt parks at NPIX after a frame so late pixels can be flagged,
  // and is cleared by the next frame start.
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      overrun <= 1'b0;
    end else begin
      fb_we <= accept;
      if (accept) begin
        fb_addr <= pix_cnt;
        fb_data <= src_color;
        pix_cnt <= pix_cnt + pix_addr_t'(1);
      end else if (frame_start) begin
        pix_cnt <= '0;
      end
      if (src_valid && full) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_source_sequencer.sv
`default_nettype none
// frame_source_sequencer: shows loading-screen frames after boot, then hands
// the framebuffer write port permanently to the main renderer.
module frame_source_sequencer
  import display_pkg::*;
#(
  parameter int WIDTH         = LCD_WIDTH,
  parameter int HEIGHT        = LCD_HEIGHT,
  parameter int MIN_LS_FRAMES = 60
) (
  input  logic                     clk_12,
  input  logic                     rst,
  frame_source_sequencer_if.master bus
);

  localparam int NPIX = WIDTH * HEIGHT;

  seq_state_t state;
  logic [7:0] ls_frames;
  logic       render_en;
  logic       sel_main;
  logic       frame_start;
  logic       frame_done;
  logic       handoff_ok;

  always_comb begin
    render_en   = (state == ST_LS_RENDER) || (state == ST_MAIN_RENDER);
    sel_main    = (state == ST_MAIN_IDLE) || (state == ST_MAIN_RENDER);
    handoff_ok  = (ls_frames >= 8'(MIN_LS_FRAMES)) && bus.app_ready;
    frame_start = bus.vsync_tick &&
                  (((state == ST_LS_IDLE) && !bus.ls_bsy) || (state == ST_MAIN_IDLE));
  end

  fb_write_mux #(
    .NPIX (NPIX)
  ) u_fb_write_mux (
    .clk_12      (clk_12),
    .rst         (rst),
    .write_en    (render_en),
    .sel_main    (sel_main),
    .frame_start (frame_start),
    .ls_valid    (bus.ls_valid),
    .ls_color    (bus.ls_color),
    .main_valid  (bus.main_valid),
    .main_color  (bus.main_color),
    .fb_we       (bus.fb_we),
    .fb_addr     (bus.fb_addr),
    .fb_data     (bus.fb_data),
    .overrun     (bus.overrun),
    .frame_done  (frame_done)
  );

  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      state              <= ST_BOOT;
      ls_frames          <= 8'd0;
      bus.ls_new_frame   <= 1'b0;
      bus.main_new_frame <= 1'b0;
      bus.loading_active <= 1'b1;
      bus.skipped_frames <= 8'd0;
    end else begin
      bus.ls_new_frame   <= 1'b0;
      bus.main_new_frame <= 1'b0;
      case (state)
        ST_BOOT: begin
          if (!bus.ls_bsy) state <= ST_LS_IDLE;
        end
        ST_LS_IDLE: begin
          if (bus.vsync_tick) begin
            if (bus.ls_bsy) begin
              bus.skipped_frames <= sat_inc8(bus.skipped_frames);
            end else if (handoff_ok) begin
              bus.main_new_frame <= 1'b1;
              bus.loading_active <= 1'b0;
              state              <= ST_MAIN_RENDER;
            end else begin
              bus.ls_new_frame <= 1'b1;
              state            <= ST_LS_RENDER;
            end
          end
        end
        ST_LS_RENDER: begin
          // A tick coinciding with the final pixel is skipped, not queued.
          if (bus.vsync_tick) bus.skipped_frames <= sat_inc8(bus.skipped_frames);
          if (frame_done) begin
            ls_frames <= sat_inc8(ls_frames);
            state     <= ST_LS_IDLE;
          end
        end
        ST_MAIN_IDLE: begin
          if (bus.vsync_tick) begin
            bus.main_new_frame <= 1'b1;
            state              <= ST_MAIN_RENDER;
          end
        end
        ST_MAIN_RENDER: begin
          if (bus.vsync_tick) bus.skipped_frames <= sat_inc8(bus.skipped_frames);
          if (frame_done) state <= ST_MAIN_IDLE;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire
